seven_seg_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for a common-segment, N-digit module. It accepts DIGITS packed BCD nibbles and scans them one digit at a time, driving shared active-low segment lines and active-low digit selects. It adds a guard blanking interval against ghosting, leading-zero suppression and optional per-digit blinking. It sits between the countdown datapath and the board display pins and replaces per-digit static decoders.

---
 rtl/seven_seg_scan.sv | 148 ++++++++++++++
 tb/tb_seven_seg_scan.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with guard blanking and leading-zero suppression.
// Optional per-digit blinking is built when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic                  blank_lz,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned PreW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || SCAN_DIV < 2 || BLANK_CYC >= SCAN_DIV || BLINK_DIV < 1) begin : g_bad_params
        $error("seven_seg_scan: illegal parameter combination");
    end

    logic [PreW-1:0]   pre_q, pre_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              slot_end;
    logic              frame_end;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              glyph_valid;
    logic              upper_zero;
    logic [DIGITS-1:0] lz_sup;
    logic              blink_sup;
    logic              active;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    assign slot_end  = (pre_q == PreW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_q == IdxW'(DIGITS - 1));

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            pre_d = '0;
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero while
    // it and everything above it are zero. Digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        lz_sup     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (digits[4*i +: 4] == 4'h0);
            lz_sup[i]  = blank_lz && upper_zero && (i != 0);
        end
    end

    assign nibble = digits[{idx_q, 2'b00} +: 4];

    always_comb begin
        glyph       = 7'b1111111;
        glyph_valid = 1'b1;
        case (nibble)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph_valid = 1'b0;
        endcase
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int unsigned FrmW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FrmW-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (frame_q == FrmW'(BLINK_DIV - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign blink_sup = phase_q && blink_mask[idx_q];
`else
    assign blink_sup = 1'b0;
`endif

    // Invalid codes also release the digit select so the slot is fully dark.
    always_comb begin
        active = enable && (pre_q >= PreW'(BLANK_CYC)) && !lz_sup[idx_q] && !blink_sup
                 && glyph_valid;
        seg_d  = 7'b1111111;
        an_d   = '1;
        if (active) begin
            seg_d = glyph;
            an_d  = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= 7'b1111111;
            an_q  <= '1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: scoreboard of expected {an, seg} per cycle.
// Blink scenario is exercised when SEVEN_SEG_BLINK_EN is defined.
`timescale 1ns/1ps
module tb_seven_seg_scan;

    localparam int unsigned D  = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned BD = 2;
    localparam logic [10:0] DARK = {4'b1111, 7'b1111111};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits = 16'h0;
`ifdef SEVEN_SEG_BLINK_EN
    logic [3:0]  blink_mask = 4'b0;
`endif
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    int m_pre = 0;
    int m_idx = 0;
    int m_frame = 0;
    bit m_phase = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .DIGITS   (D),
        .SCAN_DIV (SD),
        .BLANK_CYC(BC),
        .BLINK_DIV(BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .digits    (digits),
        .blank_lz  (blank_lz),
`ifdef SEVEN_SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg       (seg),
        .an        (an)
    );

    // At most one digit select may ever be low.
    always @(negedge clk) begin
        if (!$isunknown(an)) begin
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_err++;
                $display("FAIL onehot_an t=%0t an=%b required at most one low bit", $time, an);
            end
        end
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit mask_bit(input int i);
`ifdef SEVEN_SEG_BLINK_EN
        return blink_mask[i];
`else
        return (i < 0);
`endif
    endfunction

    // Expected output after the coming edge, then advance the model across that edge.
    task automatic tick_model(output logic [10:0] e);
        logic [3:0] nib;
        bit sup, act;
        nib = digits[m_idx*4 +: 4];
        sup = blank_lz && (m_idx > 0) && ((digits >> (4*m_idx)) == 16'h0);
        act = enable && (m_pre >= int'(BC)) && !sup && !(m_phase && mask_bit(m_idx))
              && (nib <= 4'd9);
        e = (rst || !act) ? DARK : {~(4'b0001 << m_idx), dec(nib)};
        if (rst) begin
            m_pre = 0; m_idx = 0; m_frame = 0; m_phase = 1'b0;
        end else if (m_pre == int'(SD) - 1) begin
            m_pre = 0;
            if (m_idx == int'(D) - 1) begin
                m_idx = 0;
                if (m_frame == int'(BD) - 1) begin
                    m_frame = 0;
                    m_phase = !m_phase;
                end else begin
                    m_frame++;
                end
            end else begin
                m_idx++;
            end
        end else begin
            m_pre++;
        end
    endtask

    task automatic test_reset();
        logic [10:0] me, want;
        int d;
        rst = 1'b1; enable = 1'b1; digits = 16'h1234; blank_lz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_model(me);
            exp_q.push_back(DARK);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            n_cmp++;
            if ({an, seg} !== want) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, want[10:7], want[6:0]);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick_model(me);
            d = (k / 4) % 4;
            if (k % 4 == 0) exp_q.push_back(DARK);
            else exp_q.push_back({~(4'b0001 << d), dec(digits[4*d +: 4])});
            @(posedge clk); #1;
            want = exp_q.pop_front();
            n_cmp++;
            if ({an, seg} !== want) begin
                n_err++;
                $display("FAIL reset_scan cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, want[10:7], want[6:0]);
            end
        end
    endtask

    task automatic test_lz();
        logic [10:0] me, want;
        int lit3;
        blank_lz = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            digits = (pass == 0) ? 16'h0305 : 16'h0000;
            lit3 = 0;
            for (int k = 0; k < 16; k++) begin
                tick_model(me);
                exp_q.push_back(me);
                @(posedge clk); #1;
                want = exp_q.pop_front();
                if (an[3] == 1'b0) lit3++;
                n_cmp++;
                if ({an, seg} !== want) begin
                    n_err++;
                    $display("FAIL leading_zero val=%h cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                             digits, k, an, seg, want[10:7], want[6:0]);
                end
            end
            n_cmp++;
            if (lit3 != 0) begin
                n_err++;
                $display("FAIL lz_digit3_dark val=%h got %0d lit cycles want 0", digits, lit3);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_invalid_enable();
        logic [10:0] me, want;
        int guard;
        digits = 16'h12B4;
        for (int k = 0; k < 16; k++) begin
            tick_model(me);
            exp_q.push_back(me);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            n_cmp++;
            if ({an, seg} !== want) begin
                n_err++;
                $display("FAIL invalid_code cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, want[10:7], want[6:0]);
            end
        end
        guard = 0;
        while (!(m_pre == 2 && m_idx == 0) && guard < 20) begin
            tick_model(me);
            @(posedge clk); #1;
            guard++;
        end
        enable = 1'b0;
        tick_model(me);
        exp_q.push_back(DARK);
        @(posedge clk); #1;
        want = exp_q.pop_front();
        n_cmp++;
        if ({an, seg} !== want) begin
            n_err++;
            $display("FAIL enable_drop got an=%b seg=%b want an=%b seg=%b",
                     an, seg, want[10:7], want[6:0]);
        end
        for (int k = 0; k < 18; k++) begin
            if (k == 6) enable = 1'b1;
            tick_model(me);
            exp_q.push_back(me);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            n_cmp++;
            if ({an, seg} !== want) begin
                n_err++;
                $display("FAIL enable_resume cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, want[10:7], want[6:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] me, want;
        int guard;
        digits = 16'h1234;
        guard = 0;
        while (!(m_pre == 2 && m_idx == 2) && guard < 20) begin
            tick_model(me);
            @(posedge clk); #1;
            guard++;
        end
        rst = 1'b1;
        tick_model(me);
        exp_q.push_back(DARK);
        @(posedge clk); #1;
        rst = 1'b0;
        want = exp_q.pop_front();
        n_cmp++;
        if ({an, seg} !== want) begin
            n_err++;
            $display("FAIL reset_mid got an=%b seg=%b want an=%b seg=%b",
                     an, seg, want[10:7], want[6:0]);
        end
        for (int k = 0; k < 6; k++) begin
            tick_model(me);
            if (k == 0 || k == 4) exp_q.push_back(DARK);
            else if (k < 4) exp_q.push_back({4'b1110, 7'b1001100});
            else exp_q.push_back({4'b1101, 7'b0000110});
            @(posedge clk); #1;
            want = exp_q.pop_front();
            n_cmp++;
            if ({an, seg} !== want) begin
                n_err++;
                $display("FAIL reset_restart cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, want[10:7], want[6:0]);
            end
        end
    endtask

`ifdef SEVEN_SEG_BLINK_EN
    task automatic test_blink();
        logic [10:0] me, want;
        int lit0[5];
        int lit1[5];
        int want0[5] = '{3, 3, 0, 0, 3};
        rst = 1'b1;
        tick_model(me);
        @(posedge clk); #1;
        rst = 1'b0;
        blink_mask = 4'b0001;
        digits = 16'h1234;
        for (int f = 0; f < 5; f++) begin
            lit0[f] = 0;
            lit1[f] = 0;
        end
        for (int k = 0; k < 80; k++) begin
            tick_model(me);
            exp_q.push_back(me);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            if (an == 4'b1110) lit0[k/16]++;
            if (an == 4'b1101) lit1[k/16]++;
            n_cmp++;
            if ({an, seg} !== want) begin
                n_err++;
                $display("FAIL blink cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                         k, an, seg, want[10:7], want[6:0]);
            end
        end
        for (int f = 0; f < 5; f++) begin
            n_cmp++;
            if (lit0[f] != want0[f] || lit1[f] != 3) begin
                n_err++;
                $display("FAIL blink_frame f=%0d got d0=%0d d1=%0d want d0=%0d d1=3",
                         f, lit0[f], lit1[f], want0[f]);
            end
        end
        blink_mask = 4'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_lz();
        test_invalid_enable();
        test_reset_mid();
`ifdef SEVEN_SEG_BLINK_EN
        test_blink();
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
